// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared types for the drive command arbiter:
//   cmd_t        drive command codes (STOP, FWD, LEFT, RIGHT, REV)
//   src_t        active command source (NONE, IR, CAM)
//   arb_state_t  frame sequencer states (IDLE, WAIT_ACK, GAP)
//   sanitize_cmd maps the unused codes 5..7 to STOP
// -----------------------------------------------------------------------------
package drive_pkg;

    typedef enum logic [2:0] {
        STOP  = 3'd0,
        FWD   = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        REV   = 3'd4
    } cmd_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IR   = 2'd1,
        CAM  = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2
    } arb_state_t;

    // Any code outside the defined command set must never reach the motors
    // as something other than a stop.
    function automatic cmd_t sanitize_cmd(input logic [2:0] code);
        cmd_t result;
        if (code > 3'd4) begin
            result = STOP;
        end else begin
            result = cmd_t'(code);
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// -----------------------------------------------------------------------------
// arb_timer
// Down-counter with synchronous load. Counts down by one per enabled cycle and
// parks at zero.
// Ports:
//   clk_50      clock
//   reset       asynchronous active-high reset (count -> 0)
//   load        load load_value this cycle (wins over enable)
//   load_value  value to load
//   en          decrement enable
//   zero        count is zero
// -----------------------------------------------------------------------------
module arb_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// drive_cmd_arbiter
// Chooses between the IR remote (held for HOLD_CYCLES after its last command)
// and the camera tracker, tags the command with the mic speed level and
// sequences frames to the UART JSON transmitter over a req/ack handshake with
// ack timeout and an inter-frame gap.
//
// Optional feature macro: DRIVE_ARB_KEEPALIVE_EN
//   defined   -> an unchanged selection is re-sent every KEEPALIVE_CYCLES
//   undefined -> frames only on selection change and after reset
//
// Ports:
//   clk_50     50 MHz system clock
//   reset      asynchronous active-high reset
//   ir_valid   1-cycle strobe, ir_cmd valid
//   ir_cmd     IR command code
//   cam_valid  camera target detected (level)
//   cam_dir    camera command code
//   speed      speed level, sampled at frame launch
//   tx_req     frame request to transmitter
//   tx_cmd     frame command (stable while tx_req)
//   tx_speed   frame speed (stable while tx_req)
//   tx_ack     1-cycle strobe, transmitter finished frame
//   src        active source (0 NONE, 1 IR, 2 CAM)
//   ack_err    sticky: a frame timed out waiting for tx_ack
// -----------------------------------------------------------------------------
module drive_cmd_arbiter
    import drive_pkg::*;
#(
    parameter int HOLD_CYCLES        = 25_000_000,
    parameter int KEEPALIVE_CYCLES   = 5_000_000,
    parameter int ACK_TIMEOUT_CYCLES = 1_000_000,
    parameter int GAP_CYCLES         = 16
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       ir_valid,
    input  logic [2:0] ir_cmd,
    input  logic       cam_valid,
    input  logic [2:0] cam_dir,
    input  logic [1:0] speed,
    output logic       tx_req,
    output logic [2:0] tx_cmd,
    output logic [1:0] tx_speed,
    input  logic       tx_ack,
    output logic [1:0] src,
    output logic       ack_err
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    arb_state_t state_reg;
    cmd_t       ir_cmd_reg;
    cmd_t       sel_cmd_reg, sel_cmd_next;
    src_t       src_reg, src_next;
    cmd_t       last_cmd_reg;
    src_t       last_src_reg;
    cmd_t       tx_cmd_reg;
    logic [1:0] tx_speed_reg;
    logic       tx_req_reg;
    logic       ack_err_reg;
    logic       dirty_reg;
    logic       dirty_now;
    logic       launch;
    logic       ka_expire;
    logic       hold_zero, ack_zero, gap_zero;
    logic       frame_done;

    // ---------------------------------------------------------------- timers
    arb_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk_50     (clk_50),
        .reset      (reset),
        .load       (ir_valid),
        .load_value (HOLD_W'(HOLD_CYCLES)),
        .en         (1'b1),
        .zero       (hold_zero)
    );

    // Loaded with N-1 so the timeout fires on the Nth cycle of tx_req.
    arb_timer #(.WIDTH(ACK_W)) u_ack_timer (
        .clk_50     (clk_50),
        .reset      (reset),
        .load       (launch),
        .load_value (ACK_W'(ACK_TIMEOUT_CYCLES - 1)),
        .en         (state_reg == WAIT_ACK),
        .zero       (ack_zero)
    );

    // Leaving WAIT_ACK (ack or timeout); ack has priority over timeout.
    assign frame_done = (state_reg == WAIT_ACK) && (tx_ack || ack_zero);

    // Loaded with N-1 so GAP lasts exactly N cycles.
    arb_timer #(.WIDTH(GAP_W)) u_gap_timer (
        .clk_50     (clk_50),
        .reset      (reset),
        .load       (frame_done),
        .load_value (GAP_W'(GAP_CYCLES - 1)),
        .en         (state_reg == GAP),
        .zero       (gap_zero)
    );

`ifdef DRIVE_ARB_KEEPALIVE_EN
    localparam int KA_W = $clog2(KEEPALIVE_CYCLES + 1);

    logic ka_zero;
    logic ka_armed_reg;

    // Loaded with N-1 at launch: the zero cycle is the last one before the
    // period ends, so a launch on that cycle puts the next tx_req exactly
    // KEEPALIVE_CYCLES after the previous one.
    arb_timer #(.WIDTH(KA_W)) u_keepalive_timer (
        .clk_50     (clk_50),
        .reset      (reset),
        .load       (launch),
        .load_value (KA_W'(KEEPALIVE_CYCLES - 1)),
        .en         (1'b1),
        .zero       (ka_zero)
    );

    // The timer parks at zero; armed turns that level into a single expiry.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            ka_armed_reg <= 1'b0;
        end else if (launch) begin
            ka_armed_reg <= 1'b1;
        end else if (ka_zero) begin
            ka_armed_reg <= 1'b0;
        end
    end

    assign ka_expire = ka_armed_reg && ka_zero;
`else
    assign ka_expire = 1'b0;
`endif

    // ------------------------------------------------------------- selection
    // ir_valid is honoured in its own cycle so the registered selection
    // reflects it one cycle later, before the hold timer has been loaded.
    always_comb begin
        sel_cmd_next = STOP;
        src_next     = NONE;
        if (ir_valid) begin
            sel_cmd_next = sanitize_cmd(ir_cmd);
            src_next     = IR;
        end else if (!hold_zero) begin
            sel_cmd_next = ir_cmd_reg;
            src_next     = IR;
        end else if (cam_valid) begin
            sel_cmd_next = sanitize_cmd(cam_dir);
            src_next     = CAM;
        end
    end

    // dirty_reg remembers changes seen while busy (even ones that later
    // revert); the live compare lets IDLE launch without an extra cycle.
    assign dirty_now = dirty_reg
                     || (sel_cmd_reg != last_cmd_reg)
                     || (src_reg != last_src_reg)
                     || ka_expire;

    assign launch = (state_reg == IDLE) && dirty_now;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            ir_cmd_reg   <= STOP;
            sel_cmd_reg  <= STOP;
            src_reg      <= NONE;
            last_cmd_reg <= STOP;
            last_src_reg <= NONE;
            dirty_reg    <= 1'b1;
        end else begin
            if (ir_valid) begin
                ir_cmd_reg <= sanitize_cmd(ir_cmd);
            end
            sel_cmd_reg <= sel_cmd_next;
            src_reg     <= src_next;
            if (launch) begin
                last_cmd_reg <= sel_cmd_reg;
                last_src_reg <= src_reg;
                dirty_reg    <= 1'b0;
            end else begin
                dirty_reg    <= dirty_now;
            end
        end
    end

    // ------------------------------------------------------- frame sequencer
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            tx_req_reg   <= 1'b0;
            tx_cmd_reg   <= STOP;
            tx_speed_reg <= 2'd0;
            ack_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        tx_cmd_reg   <= sel_cmd_reg;
                        tx_speed_reg <= speed;
                        tx_req_reg   <= 1'b1;
                        state_reg    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_ack) begin
                        tx_req_reg <= 1'b0;
                        state_reg  <= GAP;
                    end else if (ack_zero) begin
                        tx_req_reg  <= 1'b0;
                        ack_err_reg <= 1'b1;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    tx_req_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign tx_req   = tx_req_reg;
    assign tx_cmd   = tx_cmd_reg;
    assign tx_speed = tx_speed_reg;
    assign src      = src_reg;
    assign ack_err  = ack_err_reg;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_cmd_arbiter
// Directed bench for drive_cmd_arbiter with HOLD=100, KEEPALIVE=50,
// ACK_TIMEOUT=20, GAP=4. Expected values are hand-derived from the cycle
// behaviour of the arbiter. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_drive_cmd_arbiter;

    logic       clk_50;
    logic       reset;
    logic       ir_valid;
    logic [2:0] ir_cmd;
    logic       cam_valid;
    logic [2:0] cam_dir;
    logic [1:0] speed;
    logic       tx_req;
    logic [2:0] tx_cmd;
    logic [1:0] tx_speed;
    logic       tx_ack;
    logic [1:0] src;
    logic       ack_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    drive_cmd_arbiter #(
        .HOLD_CYCLES        (100),
        .KEEPALIVE_CYCLES   (50),
        .ACK_TIMEOUT_CYCLES (20),
        .GAP_CYCLES         (4)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .ir_valid  (ir_valid),
        .ir_cmd    (ir_cmd),
        .cam_valid (cam_valid),
        .cam_dir   (cam_dir),
        .speed     (speed),
        .tx_req    (tx_req),
        .tx_cmd    (tx_cmd),
        .tx_speed  (tx_speed),
        .tx_ack    (tx_ack),
        .src       (src),
        .ack_err   (ack_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $display("[TB] PASS %s = %0d", tag, obs);
        end
    endtask

    // Waits (bounded) for tx_req, records the frame, and optionally returns
    // tx_ack ack_after cycles after the first cycle of tx_req.
    task automatic get_frame(input int max_wait, input int ack_after,
                             output bit got, output int t_launch,
                             output logic [2:0] f_cmd, output logic [1:0] f_spd,
                             output logic [1:0] f_src);
        got      = 1'b0;
        t_launch = -1;
        f_cmd    = 3'd0;
        f_spd    = 2'd0;
        f_src    = 2'd0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk_50);
            if (tx_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            t_launch = cyc;
            f_cmd    = tx_cmd;
            f_spd    = tx_speed;
            f_src    = src;
            $display("[TB] frame at cycle %0d: cmd=%0d speed=%0d src=%0d ack_err=%0d",
                     t_launch, f_cmd, f_spd, f_src, ack_err);
            if (ack_after >= 0) begin
                repeat (ack_after) @(negedge clk_50);
                check("cmd_stable_until_ack", tx_cmd, f_cmd);
                tx_ack = 1'b1;
                @(negedge clk_50);
                tx_ack = 1'b0;
                check("req_fall_after_ack", tx_req, 1'b0);
            end
        end else begin
            $display("[TB] no frame within %0d cycles (cycle %0d)", max_wait, cyc);
        end
    endtask

    initial begin
        bit         got;
        int         t, t_ir, t_fall, t_prev, hi;
        logic [2:0] fc;
        logic [1:0] fs, fr;

        reset     = 1'b1;
        ir_valid  = 1'b0;
        ir_cmd    = 3'd0;
        cam_valid = 1'b0;
        cam_dir   = 3'd0;
        speed     = 2'd1;
        tx_ack    = 1'b0;

        // ---- reset state
        #12;
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_tx_cmd", tx_cmd, 3'd0);
        check("rst_tx_speed", tx_speed, 2'd0);
        check("rst_src", src, 2'd0);
        check("rst_ack_err", ack_err, 1'b0);

        // ---- STOP frame after reset release
        @(negedge clk_50);
        reset = 1'b0;
        get_frame(5, 3, got, t, fc, fs, fr);
        check("boot_launch", got, 1'b1);
        check("boot_cmd", fc, 3'd0);
        check("boot_speed", fs, 2'd1);
        check("boot_src", fr, 2'd0);
        check("boot_ack_err", ack_err, 1'b0);

        // ---- camera selection
        repeat (6) @(negedge clk_50);
        cam_valid = 1'b1;
        cam_dir   = 3'd2;
        speed     = 2'd2;
        get_frame(10, 3, got, t, fc, fs, fr);
        check("cam_launch", got, 1'b1);
        check("cam_cmd", fc, 3'd2);
        check("cam_src", fr, 2'd2);
        check("cam_speed", fs, 2'd2);

        // ---- IR overrides camera, tx_req two cycles after ir_valid
        repeat (8) @(negedge clk_50);
        ir_cmd   = 3'd4;
        ir_valid = 1'b1;
        @(negedge clk_50);
        ir_valid = 1'b0;
        check("ir_req_not_early", tx_req, 1'b0);
        get_frame(1, 3, got, t_ir, fc, fs, fr);
        check("ir_launch_plus2", got, 1'b1);
        check("ir_cmd", fc, 3'd4);
        check("ir_src", fr, 2'd1);

        // ---- IR hold expires, camera takes over again
`ifdef DRIVE_ARB_KEEPALIVE_EN
        t_prev = t_ir;
        for (int k = 0; k < 4; k++) begin
            get_frame(80, 3, got, t, fc, fs, fr);
            if (!got || fr != 2'd1) break;
            check("ka_ir_cmd", fc, 3'd4);
            if (k == 0) check("ka_ir_period", t - t_prev, 50);
        end
        check("hold_exp_launch", got, 1'b1);
        check("hold_exp_cmd", fc, 3'd2);
        check("hold_exp_src", fr, 2'd2);
`else
        get_frame(150, 3, got, t, fc, fs, fr);
        check("hold_exp_launch", got, 1'b1);
        check("hold_exp_time", t - t_ir, 101);
        check("hold_exp_cmd", fc, 3'd2);
        check("hold_exp_src", fr, 2'd2);
`endif

        // ---- selection churn during a stalled WAIT_ACK
        repeat (8) @(negedge clk_50);
        cam_dir = 3'd4;
        get_frame(10, -1, got, t, fc, fs, fr);
        check("stall_launch", got, 1'b1);
        check("stall_cmd", fc, 3'd4);
        cam_dir = 3'd1;
        repeat (2) @(negedge clk_50);
        check("stall_hold_a", tx_cmd, 3'd4);
        cam_dir = 3'd3;
        repeat (2) @(negedge clk_50);
        check("stall_hold_b", tx_cmd, 3'd4);
        cam_dir = 3'd1;
        repeat (2) @(negedge clk_50);
        check("stall_hold_c", tx_cmd, 3'd4);
        check("stall_req_high", tx_req, 1'b1);
        tx_ack = 1'b1;
        @(negedge clk_50);
        tx_ack = 1'b0;
        check("stall_req_fall", tx_req, 1'b0);
        t_fall = cyc;
        get_frame(12, 3, got, t, fc, fs, fr);
        check("followup_launch", got, 1'b1);
        check("followup_cmd", fc, 3'd1);
        check("followup_gap", t - t_fall, 5);
        get_frame(30, 3, got, t, fc, fs, fr);
        check("followup_only_one", got, 1'b0);

        // ---- ack on the same cycle as the timeout counts as ack
        cam_dir = 3'd2;
        get_frame(10, 19, got, t, fc, fs, fr);
        check("coinc_launch", got, 1'b1);
        check("coinc_no_err", ack_err, 1'b0);

        // ---- no ack: timeout after 20 cycles of tx_req
        repeat (8) @(negedge clk_50);
        cam_dir = 3'd3;
        get_frame(10, -1, got, t, fc, fs, fr);
        check("to_launch", got, 1'b1);
        hi = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_50);
            if (tx_req === 1'b1) hi++;
            else break;
        end
        check("to_req_cycles", hi, 20);
        check("to_ack_err", ack_err, 1'b1);
        check("to_cmd", tx_cmd, 3'd3);
        tx_ack = 1'b1;
        @(negedge clk_50);
        tx_ack = 1'b0;
        repeat (4) @(negedge clk_50);
        cam_dir = 3'd1;
        get_frame(12, 3, got, t, fc, fs, fr);
        check("post_to_launch", got, 1'b1);
        check("post_to_cmd", fc, 3'd1);
        check("post_to_err_sticky", ack_err, 1'b1);

        // ---- out-of-range camera code maps to STOP; reset mid-frame
        repeat (8) @(negedge clk_50);
        cam_dir = 3'd6;
        get_frame(12, -1, got, t, fc, fs, fr);
        check("bad_code_launch", got, 1'b1);
        check("bad_code_cmd", fc, 3'd0);
        check("bad_code_src", fr, 2'd2);
        reset = 1'b1;
        #1;
        check("async_rst_req", tx_req, 1'b0);
        check("async_rst_err", ack_err, 1'b0);
        check("async_rst_src", src, 2'd0);
        cam_valid = 1'b0;
        speed     = 2'd3;
        @(negedge clk_50);
        reset = 1'b0;

        // ---- static selection: keepalive cadence or silence
        get_frame(5, 3, got, t_prev, fc, fs, fr);
        check("reboot_launch", got, 1'b1);
        check("reboot_cmd", fc, 3'd0);
        check("reboot_speed", fs, 2'd3);
`ifdef DRIVE_ARB_KEEPALIVE_EN
        get_frame(60, 3, got, t, fc, fs, fr);
        check("ka_launch_1", got, 1'b1);
        check("ka_period_1", t - t_prev, 50);
        t_prev = t;
        get_frame(60, 3, got, t, fc, fs, fr);
        check("ka_launch_2", got, 1'b1);
        check("ka_period_2", t - t_prev, 50);
`else
        get_frame(120, 3, got, t, fc, fs, fr);
        check("no_keepalive", got, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
